i2s_audio_transmitter: RTL and testbench
========================================

Name: i2s_audio_transmitter

Overview:
- I2S master transmitter, the playback-direction counterpart of the INMP441 microphone receiver path.
- Generates sck and ws from clk and shifts out stereo samples on sd, MSB-first, standard I2S format. Targets DACs and amplifiers such as the MAX98357 and PCM5102.
- Has a one-frame holding buffer with valid/ready handshake toward the audio source, plus underrun detection.

Parameters:
- SAMPLE_WIDTH, 24: bits per channel sample transmitted.
- SLOT_WIDTH, 32: sck periods per channel slot. Must be greater than SAMPLE_WIDTH.
- SCK_DIV_LOG2, 3: sck half-period is 2^SCK_DIV_LOG2 clk cycles, so sck period is 16 clk by default.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- in_left  input  SAMPLE_WIDTH  left sample, two's complement.
- in_right  input  SAMPLE_WIDTH  right sample.
- in_valid  input  1  source presents a stereo pair.
- in_ready  output  1  holding buffer empty; pair accepted when in_valid & in_ready.
- sck  output  1  I2S bit clock.
- ws  output  1  word select; 0 = left, 1 = right.
- sd  output  1  serial data.
- frame_start  output  1  one-clk pulse on the cycle a frame load occurs.
- underrun  output  1  one-clk pulse when a frame load finds the holding buffer empty.

Behaviour:
- Reset (async, rst=1):
  - cnt=0, pos=0, sck=0, ws=0, sd=0.
  - Holding buffer empty, in_ready=1, shift registers zero, frame_start=0, underrun=0.
- Clock generation:
  - cnt is a free-running (SCK_DIV_LOG2+1)-bit counter; sck = cnt[SCK_DIV_LOG2], taken directly from the register.
  - fall_tick = (cnt == all ones). On the next edge sck goes 1→0.
- Bit position:
  - pos counts 0..2*SLOT_WIDTH-1 and increments on each fall_tick, wrapping to 0.
  - ws and sd are registers updated on the same edge that pos updates (sck falling). Receivers sample on sck rising.
- ws mapping: ws=0 for pos 0..SLOT_WIDTH-1; ws=1 for pos SLOT_WIDTH..2*SLOT_WIDTH-1.
- sd mapping (one-sck I2S delay after the ws edge):
  - pos 1..SAMPLE_WIDTH: left bits, MSB first.
  - pos SLOT_WIDTH+1..SLOT_WIDTH+SAMPLE_WIDTH: right bits, MSB first.
  - All other pos: 0.
- Frame load:
  - Occurs on the fall_tick where pos wraps 2*SLOT_WIDTH-1→0.
  - If the holding buffer is full: copy it to the shift registers, mark it empty, pulse frame_start.
  - If the holding buffer is empty: load zeros, pulse frame_start and underrun.
  - The first frame after reset has no load event. It transmits zeros and does not flag underrun.
- Handshake:
  - in_ready = holding empty (registered state, no combinational path from in_valid).
  - On accept, latch in_left/in_right; in_ready drops the next cycle.
  - Accept and load on the same cycle with the buffer empty: the load sees empty (underrun, zeros sent). The new pair is stored for the next frame.
  - With the buffer full, in_valid is ignored.
- Latency: a pair accepted during frame N is transmitted in frame N+1. The left MSB appears on sd one sck period after the ws falling edge.
- Frame length: 2*SLOT_WIDTH*2^(SCK_DIV_LOG2+1) clk, i.e. 1024 clk by default.
- Reset mid-frame: all state returns to reset values immediately. sck, ws and sd are forced low and any buffered pair is discarded.

Optional Feature:
- Macro: I2S_TX_UNDERRUN_REPEAT_EN.
- Defined: a load with the holding buffer empty re-transmits the previously transmitted pair (kept in a last-pair register, zero after reset). The underrun pulse is still generated.
- Undefined: an underrun transmits zeros, as in Behaviour.

Test Plan:
- Clock check: release reset, count clk between sck edges. Required: sck period 16 clk; ws period 1024 clk; ws toggles 1 clk after a cycle with cnt=15.
- Single pair: after reset, pulse in_valid with left=24'hA5A5A5, right=24'h5A5A5A. Required:
  - in_ready drops next cycle.
  - Next load: frame_start=1, underrun=0, in_ready=1 again.
  - Bits sampled on sck rising at pos 1..24 read 24'hA5A5A5; pos 33..56 read 24'h5A5A5A; all other pos read 0.
- Underrun: provide no data for a frame. Required: underrun pulses once at the load; sd stays 0 for the whole frame (macro undefined). With I2S_TX_UNDERRUN_REPEAT_EN defined, A5A5A5/5A5A5A is repeated.
- Backpressure: hold in_valid high with an incrementing pair every accept. Required: exactly one accept per frame; no underrun after the first load; transmitted pairs are consecutive with none skipped.
- Same-cycle collision: assert in_valid with the buffer empty on the load cycle. Required: underrun=1 that cycle; the pair is transmitted in the following frame.
- Reset mid-frame: assert rst at pos 10 with the buffer full. Required: sck=ws=sd=0 and in_ready=1 asynchronously; the next frame transmits zeros.

Source files
------------

// File: rtl/i2s_audio_transmitter.sv
// i2s_audio_transmitter: I2S master transmitter, stereo samples MSB-first, one-frame holding buffer.
// Ports: clk, rst (async, active-high); in_left/in_right/in_valid/in_ready source handshake;
//        sck/ws/sd I2S bus; frame_start and underrun one-clk pulses on the frame-load cycle.
// Macro I2S_TX_UNDERRUN_REPEAT_EN: an underrun re-sends the last transmitted pair instead of zeros.
module i2s_audio_transmitter #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int SCK_DIV_LOG2 = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] in_left,
  input  logic [SAMPLE_WIDTH-1:0] in_right,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    sck,
  output logic                    ws,
  output logic                    sd,
  output logic                    frame_start,
  output logic                    underrun
);
  localparam int CW = SCK_DIV_LOG2 + 1;
  localparam int PW = $clog2(2 * SLOT_WIDTH);
  localparam logic [PW-1:0] LAST = PW'(2 * SLOT_WIDTH - 1);
  logic [CW-1:0] cnt;
  logic [PW-1:0] pos, pos_n;
  logic fall_tick, load, accept, left_bit, right_bit, hold_full;
  logic [SAMPLE_WIDTH-1:0] hold_l, hold_r, sh_l, sh_r, load_l, load_r;
  assign fall_tick   = &cnt;
  assign load        = fall_tick && pos == LAST;
  assign pos_n       = load ? '0 : pos + 1'b1;
  // sd is registered together with pos, so the bit windows are judged on the upcoming position
  assign left_bit    = pos_n >= PW'(1) && pos_n <= PW'(SAMPLE_WIDTH);
  assign right_bit   = pos_n >= PW'(SLOT_WIDTH + 1) && pos_n <= PW'(SLOT_WIDTH + SAMPLE_WIDTH);
  assign sck         = cnt[CW-1];
  assign in_ready    = !hold_full;
  assign accept      = in_valid && !hold_full;
  assign frame_start = load;
  assign underrun    = load && !hold_full;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [SAMPLE_WIDTH-1:0] last_l, last_r;
  assign load_l = hold_full ? hold_l : last_l;
  assign load_r = hold_full ? hold_r : last_r;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_l <= '0;
      last_r <= '0;
    end else if (load) begin
      last_l <= load_l;
      last_r <= load_r;
    end
`else
  assign load_l = hold_full ? hold_l : '0;
  assign load_r = hold_full ? hold_r : '0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      pos <= '0;
      ws  <= 1'b0;
      sd  <= 1'b0;
      sh_l <= '0;
      sh_r <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (fall_tick) begin
        pos <= pos_n;
        ws  <= pos_n >= PW'(SLOT_WIDTH);
        sd  <= left_bit ? sh_l[SAMPLE_WIDTH-1] : right_bit & sh_r[SAMPLE_WIDTH-1];
        if (load) begin
          sh_l <= load_l;
          sh_r <= load_r;
        end else begin
          if (left_bit) sh_l <= {sh_l[SAMPLE_WIDTH-2:0], 1'b0};
          if (right_bit) sh_r <= {sh_r[SAMPLE_WIDTH-2:0], 1'b0};
        end
      end
    end
  // a load and an accept never coincide with a full buffer, so accept wins only when it was empty
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_full <= 1'b0;
      hold_l <= '0;
      hold_r <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_l <= in_left;
      hold_r <= in_right;
    end else if (load) begin
      hold_full <= 1'b0;
    end
endmodule

// File: tb/tb_i2s_audio_transmitter.sv
// tb_i2s_audio_transmitter: randomized self-checking bench with a frame-level reference model.
module tb_i2s_audio_transmitter;
  localparam int SW = 24;
  localparam int SL = 32;
  localparam int FRAME = 1024;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [SW-1:0] in_left = '0;
  logic [SW-1:0] in_right = '0;
  logic in_valid = 1'b0;
  logic in_ready, sck, ws, sd, frame_start, underrun;
  int checks = 0;
  int errors = 0;
  int cyc;
  logic m_full;
  logic [SW-1:0] m_hl, m_hr, m_cl, m_cr, tx_l, tx_r;

  i2s_audio_transmitter dut (
    .clk(clk), .rst(rst), .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
    .in_ready(in_ready), .sck(sck), .ws(ws), .sd(sd), .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // reference: cyc is clk cycles since reset release; a frame is 1024 cycles, load at the last one
  always @(posedge clk or posedge rst)
    if (rst) begin
      cyc = 0; m_full = 0; m_hl = '0; m_hr = '0; m_cl = '0; m_cr = '0;
    end else begin : model
      logic ld, acc;
      ld = (cyc % FRAME) == FRAME - 1;
      acc = in_valid && !m_full;
      if (ld) begin
        if (m_full) begin m_cl = m_hl; m_cr = m_hr; m_full = 0; end
`ifndef I2S_TX_UNDERRUN_REPEAT_EN
        else begin m_cl = '0; m_cr = '0; end
`endif
      end
      if (acc) begin m_hl = in_left; m_hr = in_right; m_full = 1; end
      cyc++;
    end

  function automatic logic exp_sd(int c);
    int p;
    p = (c / 16) % 64;
    if (p >= 1 && p <= SW) return m_cl[SW-p];
    if (p >= SL + 1 && p <= SL + SW) return m_cr[SL+SW-p];
    return 1'b0;
  endfunction

  always @(negedge clk) begin : monitor
    logic [5:0] got, exp;
    got = {sck, ws, sd, in_ready, frame_start, underrun};
    exp = {(cyc % 16) >= 8, ((cyc / 16) % 64) >= SL, exp_sd(cyc), !m_full,
           (cyc % FRAME) == FRAME - 1, (cyc % FRAME) == FRAME - 1 && !m_full};
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors < 10) $display("FAIL monitor cyc=%0d sck,ws,sd,rdy,fs,ur got=%b exp=%b", cyc, got, exp);
    end
  end

  task automatic wait_mod(input int m);
    int n = 0;
    while ((cyc % FRAME) != m && n < 3 * FRAME) begin @(negedge clk); n++; end
    checks++;
    if ((cyc % FRAME) != m) begin errors++; $display("FAIL wait_mod timeout got=%0d want=%0d", cyc % FRAME, m); end
  endtask

  task automatic sample_frame(output logic [SW-1:0] l, output logic [SW-1:0] r, output logic other);
    int p;
    l = '0; r = '0; other = 1'b0;
    wait_mod(0);
    for (int i = 0; i < FRAME; i++) begin
      if (cyc % 16 == 8) begin
        p = (cyc / 16) % 64;
        if (p >= 1 && p <= SW) l[SW-p] = sd;
        else if (p >= SL + 1 && p <= SL + SW) r[SL+SW-p] = sd;
        else other = other | sd;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++; if (sck !== 0) begin errors++; $display("FAIL reset_sck got=%b want=0", sck); end
    checks++; if ({ws, sd} !== 2'b00) begin errors++; $display("FAIL reset_ws_sd got=%b want=00", {ws, sd}); end
    checks++; if (in_ready !== 1) begin errors++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    checks++; if ({frame_start, underrun} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b want=00", {frame_start, underrun}); end
    rst = 0;
  endtask

  task automatic test_clock;
    int r1 = -1, r2 = -1, w1 = -1, w2 = -1;
    logic ps, pw;
    ps = sck; pw = ws;
    for (int i = 0; i < 2600 && w2 < 0; i++) begin
      @(negedge clk);
      if (sck && !ps) begin if (r1 < 0) r1 = cyc; else if (r2 < 0) r2 = cyc; end
      if (!ws && pw) begin if (w1 < 0) w1 = cyc; else if (w2 < 0) w2 = cyc; end
      ps = sck; pw = ws;
    end
    checks++; if (r2 - r1 !== 16) begin errors++; $display("FAIL sck_period got=%0d want=16", r2 - r1); end
    checks++; if (w2 - w1 !== FRAME) begin errors++; $display("FAIL ws_period got=%0d want=%0d", w2 - w1, FRAME); end
    checks++; if (w1 % 16 !== 0) begin errors++; $display("FAIL ws_phase got=%0d want=0", w1 % 16); end
  endtask

  task automatic test_single_pair;
    logic [SW-1:0] gl, gr;
    logic go;
    rst = 1; @(negedge clk); rst = 0;
    in_left = 24'hA5A5A5; in_right = 24'h5A5A5A; in_valid = 1;
    @(negedge clk); in_valid = 0;
    checks++; if (in_ready !== 0) begin errors++; $display("FAIL single_ready_drop got=%b want=0", in_ready); end
    wait_mod(FRAME - 1);
    checks++; if (frame_start !== 1) begin errors++; $display("FAIL single_fs got=%b want=1", frame_start); end
    checks++; if (underrun !== 0) begin errors++; $display("FAIL single_ur got=%b want=0", underrun); end
    @(negedge clk);
    checks++; if (in_ready !== 1) begin errors++; $display("FAIL single_ready_back got=%b want=1", in_ready); end
    sample_frame(gl, gr, go);
    checks++; if (gl !== 24'hA5A5A5) begin errors++; $display("FAIL single_left got=%h want=a5a5a5", gl); end
    checks++; if (gr !== 24'h5A5A5A) begin errors++; $display("FAIL single_right got=%h want=5a5a5a", gr); end
    checks++; if (go !== 0) begin errors++; $display("FAIL single_idle_bits got=%b want=0", go); end
  endtask

  task automatic test_underrun;
    logic [SW-1:0] gl, gr, el, er;
    logic go;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    el = 24'hA5A5A5; er = 24'h5A5A5A;
`else
    el = '0; er = '0;
`endif
    wait_mod(FRAME - 1);
    checks++; if (underrun !== 1) begin errors++; $display("FAIL underrun_pulse got=%b want=1", underrun); end
    sample_frame(gl, gr, go);
    checks++; if ({gl, gr, go} !== {el, er, 1'b0}) begin errors++; $display("FAIL underrun_frame got=%h/%h/%b want=%h/%h/0", gl, gr, go, el, er); end
  endtask

  task automatic test_back_to_back;
    int base = int'($urandom);
    int k = 0, acc = 0, c, p;
    logic fired = 0;
    logic [SW-1:0] rl = '0, rr = '0;
    wait_mod(0);
    in_left = SW'(base); in_right = ~SW'(base); in_valid = 1;
    for (int i = 0; i < 5 * FRAME; i++) begin
      if (fired) begin k++; in_left = SW'(base + k); in_right = ~SW'(base + k); end
      fired = in_ready;
      acc += int'(in_ready);
      c = cyc % FRAME; p = (cyc / 16) % 64;
      if (c % 16 == 8) begin
        if (p >= 1 && p <= SW) rl[SW-p] = sd;
        else if (p >= SL + 1 && p <= SL + SW) rr[SL+SW-p] = sd;
      end
      if (c == FRAME - 1) begin
        checks++; if (acc !== 1) begin errors++; $display("FAIL b2b_accepts got=%0d want=1", acc); end
        checks++; if (underrun !== 0) begin errors++; $display("FAIL b2b_underrun got=%b want=0", underrun); end
        if (i >= FRAME) begin
          checks++;
          if (rl !== SW'(base + i / FRAME - 1) || rr !== ~SW'(base + i / FRAME - 1)) begin
            errors++; $display("FAIL b2b_pair got=%h/%h want=%h/%h", rl, rr, SW'(base + i / FRAME - 1), ~SW'(base + i / FRAME - 1));
          end
        end
        acc = 0;
      end
      @(negedge clk);
    end
    in_valid = 0;
    tx_l = SW'(base + 4); tx_r = ~SW'(base + 4);
  endtask

  task automatic test_collision;
    logic [SW-1:0] l, r, gl, gr, el, er;
    logic go;
    l = SW'($urandom); r = SW'($urandom);
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    el = tx_l; er = tx_r;
`else
    el = '0; er = '0;
`endif
    wait_mod(FRAME - 1);
    in_left = l; in_right = r; in_valid = 1;
    #1;
    checks++; if (underrun !== 1) begin errors++; $display("FAIL collide_ur got=%b want=1", underrun); end
    checks++; if (frame_start !== 1) begin errors++; $display("FAIL collide_fs got=%b want=1", frame_start); end
    @(negedge clk); in_valid = 0;
    checks++; if (in_ready !== 0) begin errors++; $display("FAIL collide_stored got=%b want=0", in_ready); end
    sample_frame(gl, gr, go);
    checks++; if ({gl, gr, go} !== {el, er, 1'b0}) begin errors++; $display("FAIL collide_gap got=%h/%h want=%h/%h", gl, gr, el, er); end
    sample_frame(gl, gr, go);
    checks++; if ({gl, gr, go} !== {l, r, 1'b0}) begin errors++; $display("FAIL collide_pair got=%h/%h want=%h/%h", gl, gr, l, r); end
  endtask

  task automatic test_reset_mid_frame;
    logic [SW-1:0] gl, gr;
    logic go;
    in_left = '1; in_right = SW'($urandom); in_valid = 1;
    @(negedge clk); in_valid = 0;
    wait_mod(FRAME - 1);
    @(negedge clk);
    in_valid = 1; @(negedge clk); in_valid = 0;
    wait_mod(168);
    #2 rst = 1;
    #1;
    checks++; if (sck !== 0) begin errors++; $display("FAIL midrst_sck got=%b want=0", sck); end
    checks++; if ({ws, sd} !== 2'b00) begin errors++; $display("FAIL midrst_ws_sd got=%b want=00", {ws, sd}); end
    checks++; if (in_ready !== 1) begin errors++; $display("FAIL midrst_ready got=%b want=1", in_ready); end
    @(negedge clk); rst = 0;
    sample_frame(gl, gr, go);
    checks++; if ({gl, gr, go} !== '0) begin errors++; $display("FAIL midrst_frame0 got=%h/%h/%b want=0", gl, gr, go); end
    sample_frame(gl, gr, go);
    checks++; if ({gl, gr, go} !== '0) begin errors++; $display("FAIL midrst_frame1 got=%h/%h/%b want=0", gl, gr, go); end
  endtask

  initial begin
    test_reset();
    test_clock();
    test_single_pair();
    test_underrun();
    test_back_to_back();
    test_collision();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
